rp_asg_stream: RTL

//  Parametrised ASG readout engine, successor to the fixed 64b/14b AXI ASG datapath. Consumes
//  DW-bit words (NUM_SAMPS=DW/SW packed samples) from the data-FIFO read side, unpacks them,

---
 rtl/rp_asg_pkg.sv | 19 +
 rtl/rp_asg_unpack.sv | 80 ++++++++
 rtl/rp_asg_stream.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rp_asg_pkg.sv
// rp_asg_pkg: shared types and defaults for the ASG stream readout engine.
// Provides the FSM state type, default word/lane widths and a lane-count helper.
package rp_asg_pkg;

    typedef enum logic [1:0] {
        ASG_IDLE = 2'd0,
        ASG_ARM  = 2'd1,
        ASG_RUN  = 2'd2,
        ASG_DONE = 2'd3
    } asg_state_t;

    localparam int ASG_DW = 64;
    localparam int ASG_SW = 16;

    function automatic int num_samps(input int dw, input int sw);
        return dw / sw;
    endfunction

endpackage

// File: rtl/rp_asg_unpack.sv
// rp_asg_unpack: one-word buffer, lane pointer and registered DAC lane mux.
// Ports: clk/rst, flush, load_en, run, adv, hold, idle, s_* word side, full/buf_last/lane_end, dac/dac_val.
module rp_asg_unpack
    import rp_asg_pkg::*;
#(
    parameter int DW   = ASG_DW,
    parameter int SW   = ASG_SW,
    parameter int DACW = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            load_en,
    input  logic            run,
    input  logic            adv,
    input  logic            hold,
    input  logic [DACW-1:0] idle,
    input  logic [DW-1:0]   s_dat,
    input  logic            s_last,
    input  logic            s_val,
    output logic            s_rdy,
    output logic            full,
    output logic            buf_last,
    output logic            lane_end,
    output logic [DACW-1:0] dac,
    output logic            dac_val
);

    localparam int NS = num_samps(DW, SW);
    localparam int LW = (NS > 1) ? $clog2(NS) : 1;

    logic [DW-1:0] buf_q;
    logic [LW-1:0] lane;
    logic          accept;

    assign lane_end = (lane == LW'(NS - 1));
    // A word may be taken in the same cycle the final lane leaves.
    assign s_rdy    = load_en && (!full || (adv && lane_end));
    assign accept   = s_val && s_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q    <= '0;
            buf_last <= 1'b0;
            full     <= 1'b0;
            lane     <= '0;
        end else if (flush) begin
            buf_last <= 1'b0;
            full     <= 1'b0;
            lane     <= '0;
        end else begin
            if (adv)
                lane <= lane_end ? '0 : lane + 1'b1;
            if (accept) begin
                buf_q    <= s_dat;
                buf_last <= s_last;
                full     <= 1'b1;
            end else if (adv && lane_end) begin
                full <= 1'b0;
            end
        end
    end

    // Starved RUN either freezes the last sample or falls back to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dac     <= '0;
            dac_val <= 1'b0;
        end else begin
            dac_val <= 1'b0;
            if (run && !flush && full) begin
                dac     <= buf_q[lane*SW +: DACW];
                dac_val <= 1'b1;
            end else if (!(run && !flush && hold)) begin
                dac <= idle;
            end
        end
    end

endmodule

// File: rtl/rp_asg_stream.sv
// rp_asg_stream: ASG readout engine, unpacks DW-bit words into DAC samples with decimation/repeat.
// Ports: dac_clk_i/dac_rst_i, cfg_*, trig_i, s_dat/last/val/rdy, dac_o/dac_val_o, status; ASG_STREAM_DIAG_EN adds window counters.
module rp_asg_stream
    import rp_asg_pkg::*;
#(
    parameter int DW   = ASG_DW,
    parameter int SW   = ASG_SW,
    parameter int DACW = 14,
    parameter int DECW = 16,
    parameter int REPW = 16,
    parameter int SEC  = 125000000
) (
    input  logic            dac_clk_i,
    input  logic            dac_rst_i,
    input  logic            cfg_en_i,
    input  logic [DECW-1:0] cfg_dec_i,
    input  logic [REPW-1:0] cfg_rep_i,
    input  logic [DACW-1:0] cfg_idle_i,
    input  logic            cfg_urun_hold_i,
    input  logic            trig_i,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_last_i,
    input  logic            s_val_i,
    output logic            s_rdy_o,
    output logic [DACW-1:0] dac_o,
    output logic            dac_val_o,
    output asg_state_t      state_o,
    output logic            last_o,
    output logic            urun_o,
    output logic [REPW-1:0] rep_cnt_o,
    output logic [31:0]     err_cnt_o,
    output logic [31:0]     transf_cnt_o
);

    asg_state_t      state_q;
    logic            trig_pend;
    logic [DECW-1:0] dec_cnt;
    logic [REPW-1:0] rep_cnt;
    logic            starve_q;

    logic run;
    logic arm;
    logic full;
    logic buf_last;
    logic lane_end;
    logic adv;
    logic rel;
    logic fin;
    logic stall;
    logic urun_ev;

    assign run     = (state_q == ASG_RUN);
    assign arm     = (state_q == ASG_ARM);
    assign adv     = run && full && (dec_cnt >= cfg_dec_i);
    assign rel     = adv && lane_end;
    assign fin     = rel && buf_last && (cfg_rep_i != '0)
                     && ((rep_cnt + 1'b1) == cfg_rep_i);
    assign stall   = run && !full;
    // One event per starved stretch, not per starved cycle.
    assign urun_ev = stall && !starve_q && cfg_en_i;

    rp_asg_unpack #(
        .DW   (DW),
        .SW   (SW),
        .DACW (DACW)
    ) u_unpack (
        .clk      (dac_clk_i),
        .rst      (dac_rst_i),
        .flush    (!cfg_en_i),
        .load_en  (arm || run),
        .run      (run),
        .adv      (adv),
        .hold     (cfg_urun_hold_i),
        .idle     (cfg_idle_i),
        .s_dat    (s_dat_i),
        .s_last   (s_last_i),
        .s_val    (s_val_i),
        .s_rdy    (s_rdy_o),
        .full     (full),
        .buf_last (buf_last),
        .lane_end (lane_end),
        .dac      (dac_o),
        .dac_val  (dac_val_o)
    );

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state_q   <= ASG_IDLE;
            trig_pend <= 1'b0;
            dec_cnt   <= '0;
            rep_cnt   <= '0;
            starve_q  <= 1'b0;
            last_o    <= 1'b0;
            urun_o    <= 1'b0;
        end else begin
            last_o   <= 1'b0;
            urun_o   <= urun_ev;
            starve_q <= stall && cfg_en_i;
            if (!cfg_en_i) begin
                state_q   <= ASG_IDLE;
                trig_pend <= 1'b0;
            end else begin
                unique case (state_q)
                    ASG_IDLE: state_q <= ASG_ARM;
                    ASG_ARM: begin
                        if (trig_i)
                            trig_pend <= 1'b1;
                        if (trig_pend && full) begin
                            state_q   <= ASG_RUN;
                            trig_pend <= 1'b0;
                            dec_cnt   <= '0;
                            rep_cnt   <= '0;
                        end
                    end
                    ASG_RUN: begin
                        if (adv)
                            dec_cnt <= '0;
                        else if (full)
                            dec_cnt <= dec_cnt + 1'b1;
                        if (rel && buf_last && (rep_cnt != '1))
                            rep_cnt <= rep_cnt + 1'b1;
                        if (fin) begin
                            state_q <= ASG_DONE;
                            last_o  <= 1'b1;
                        end
                    end
                    ASG_DONE: state_q <= ASG_DONE;
                    default:  state_q <= ASG_IDLE;
                endcase
            end
        end
    end

    assign state_o   = state_q;
    assign rep_cnt_o = rep_cnt;

`ifdef ASG_STREAM_DIAG_EN
    logic        accept;
    logic [31:0] win_cnt;
    logic [31:0] err_acc;
    logic [31:0] xfer_acc;
    logic [31:0] err_q;
    logic [31:0] xfer_q;

    assign accept = s_val_i && s_rdy_o;

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            win_cnt  <= '0;
            err_acc  <= '0;
            xfer_acc <= '0;
            err_q    <= '0;
            xfer_q   <= '0;
        end else if (win_cnt == 32'(SEC - 1)) begin
            win_cnt  <= '0;
            err_q    <= err_acc + 32'(urun_ev);
            xfer_q   <= xfer_acc + 32'(accept);
            err_acc  <= '0;
            xfer_acc <= '0;
        end else begin
            win_cnt  <= win_cnt + 32'd1;
            err_acc  <= err_acc + 32'(urun_ev);
            xfer_acc <= xfer_acc + 32'(accept);
        end
    end

    assign err_cnt_o    = err_q;
    assign transf_cnt_o = xfer_q;
`else
    assign err_cnt_o    = '0;
    assign transf_cnt_o = '0;
`endif

endmodule
